segment_mux_n: RTL and testbench



---
 rtl/segment_mux_n_pkg.sv | 18 +
 rtl/segment_mux_n_if.sv | 16 +
 rtl/segment_mux_n_seg7_hex_font.sv | 9 +
 rtl/segment_mux_n.sv | 101 ++++++++++
 tb/tb_segment_mux_n.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/segment_mux_n_pkg.sv
// Shared constants for the multiplexed 7-segment display driver and other display users.
// Holds the hex font, the blank pattern and the digit-count limit.
package segment_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  // Active-low segment patterns, bit 6 = g ... bit 0 = a
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int unsigned width_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/segment_mux_n_if.sv
// Display bus between the data source (master) and the segment scanner (slave).
// Signal names match the legacy scanner pins.
interface segment_mux_n_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          brightness;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                dp;

  modport master (output in, dp_in, blank, brightness, input seg, an, dp);
  modport slave  (input in, dp_in, blank, brightness, output seg, an, dp);
endinterface

// File: rtl/segment_mux_n_seg7_hex_font.sv
// Combinational hex nibble to active-low 7-segment decoder (g..a).
module seg7_hex_font
  import segment_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  assign seg_o = FONT[nibble_i];
endmodule

// File: rtl/segment_mux_n.sv
// Multiplexed common-anode display scanner with prescaler, PWM dimming and frame-synchronous
// input capture. Optional leading-zero blanking when SEGMENT_LZB_EN is defined.
module segment_mux_n
  import segment_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned CLK_DIV = 1
) (
  input logic            clk,
  input logic            rst,
  segment_mux_n_if.slave bus
);
  localparam int unsigned PW = width_min1(CLK_DIV);
  localparam int unsigned IW = width_min1(DIGITS);

  logic [PW-1:0]       pre_q;
  logic [IW-1:0]       idx_q;
  logic [3:0]          pwm_q;
  logic [4*DIGITS-1:0] shadow_in_q;
  logic [DIGITS-1:0]   shadow_dp_q;
  logic [DIGITS-1:0]   shadow_blank_q;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                dp_q, dp_d;

  logic                slot_end, last_digit, digit_on, lz_dark;
  logic [3:0]          nibble;
  logic [6:0]          font_seg;

  assign slot_end   = (pre_q == PW'(CLK_DIV - 1));
  assign last_digit = (idx_q == IW'(DIGITS - 1));
  assign nibble     = shadow_in_q[{idx_q, 2'b00} +: 4];

  seg7_hex_font u_font (
    .nibble_i (nibble),
    .seg_o    (font_seg)
  );

`ifdef SEGMENT_LZB_EN
  logic [DIGITS-1:0] lz;
  // Digit i is a leading zero when it and every more-significant nibble are zero
  always_comb begin
    lz = '0;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      lz[i] = ((shadow_in_q >> (4 * i)) == '0);
    end
  end
  assign lz_dark = lz[idx_q];
`else
  assign lz_dark = 1'b0;
`endif

  assign digit_on = ~shadow_blank_q[idx_q] & ~lz_dark &
                    ((bus.brightness == 4'hF) | (pwm_q < bus.brightness));

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (digit_on) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = font_seg;
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q          <= '0;
      idx_q          <= '0;
      pwm_q          <= '0;
      shadow_in_q    <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      seg_q          <= SEG_BLANK;
      an_q           <= '1;
      dp_q           <= 1'b1;
    end else begin
      pwm_q <= pwm_q + 4'd1;
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
      if (slot_end) begin
        pre_q <= '0;
        idx_q <= last_digit ? '0 : idx_q + 1'b1;
        if (last_digit) begin
          shadow_in_q    <= bus.in;
          shadow_dp_q    <= bus.dp_in;
          shadow_blank_q <= bus.blank;
        end
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_segment_mux_n.sv
// Self-checking bench for segment_mux_n (DIGITS=4, CLK_DIV=4) against a cycle-count reference model.
module tb_segment_mux_n;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FRAME   = DIGITS * CLK_DIV;
`ifdef SEGMENT_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  segment_mux_n_if #(.DIGITS(DIGITS)) bus ();

  segment_mux_n #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] font_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference: every scan quantity is derived from the cycle count since reset
  int unsigned t;
  logic [15:0] sh_in;
  logic [3:0]  sh_dp, sh_blank;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;
  logic [11:0] m_out;

  always @(posedge clk) begin
    int unsigned d, p;
    bit on;
    if (rst) begin
      t = 0; sh_in = '0; sh_dp = '0; sh_blank = '0;
      m_an = '1; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      d  = (t / CLK_DIV) % DIGITS;
      p  = t % 16;
      on = !sh_blank[d] && (bus.brightness == 15 || p < bus.brightness);
      if (LZB && d > 0 && (sh_in >> (4 * d)) == 0) on = 1'b0;
      m_an  = on ? ~(4'b0001 << d) : 4'hF;
      m_seg = on ? font_t[(sh_in >> (4 * d)) & 16'hF] : 7'h7F;
      m_dp  = on ? ~sh_dp[d] : 1'b1;
      if (t % FRAME == FRAME - 1) begin
        sh_in = bus.in; sh_dp = bus.dp_in; sh_blank = bus.blank;
      end
      t++;
    end
    m_out = {m_an, m_seg, m_dp};
  end

  task automatic set_inputs(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bl,
                            input logic [3:0] br);
    bus.in = v; bus.dp_in = dpv; bus.blank = bl; bus.brightness = br;
  endtask

  // Waits for the first output cycle of digit 0 (start of a displayed frame)
  task automatic sync_frame(output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = bus.an;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (bus.an == 4'b1110 && prev != 4'b1110) begin ok = 1'b1; break; end
      prev = bus.an;
    end
  endtask

  task automatic test_reset();
    set_inputs(16'h0, 4'h0, 4'h0, 4'hF);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.an, bus.seg, bus.dp} !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++; $display("FAIL reset: got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", bus.an, bus.seg, bus.dp);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'h40) begin
      n_fail++; $display("FAIL reset_first_digit: got an=%b seg=%h want an=1110 seg=40", bus.an, bus.seg);
    end
  endtask

  task automatic test_scan_order();
    bit ok;
    logic [6:0] exp_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    set_inputs(16'h12AF, 4'h0, 4'h0, 4'hF);
    repeat (2 * FRAME) begin
      @(negedge clk); n_checks++;
      if ({bus.an, bus.seg, bus.dp} !== m_out) begin
        n_fail++; $display("FAIL scan_model: got %h want %h", {bus.an, bus.seg, bus.dp}, m_out);
      end
    end
    sync_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL scan_sync: got no frame start want an=1110"); end
    for (int k = 0; k < 16; k++) begin
      logic [3:0] ea;
      if (k > 0) @(negedge clk);
      ea = ~(4'b0001 << (k / 4));
      n_checks++;
      if (bus.an !== ea || bus.seg !== exp_seg[k / 4] || bus.dp !== 1'b1) begin
        n_fail++;
        $display("FAIL scan_step%0d: got an=%b seg=%h dp=%b want an=%b seg=%h dp=1",
                 k, bus.an, bus.seg, bus.dp, ea, exp_seg[k / 4]);
      end
    end
  endtask

  task automatic test_pwm();
    int lows;
    set_inputs(16'h8888, 4'h0, 4'h0, 4'd4);
    repeat (2 * FRAME) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      lows = 0;
      repeat (16) begin
        @(negedge clk); n_checks++;
        if ({bus.an, bus.seg, bus.dp} !== m_out) begin
          n_fail++; $display("FAIL pwm_model: got %h want %h", {bus.an, bus.seg, bus.dp}, m_out);
        end
        if (bus.an != 4'hF) begin
          lows++;
          n_checks++;
          if (bus.seg !== 7'h00) begin n_fail++; $display("FAIL pwm_seg: got %h want 00", bus.seg); end
        end
      end
      n_checks++;
      if (lows != 4) begin n_fail++; $display("FAIL pwm_duty: got %0d low cycles want 4", lows); end
    end
    bus.brightness = 4'd0;
    @(negedge clk);
    repeat (32) begin
      @(negedge clk); n_checks++;
      if (bus.an !== 4'hF) begin n_fail++; $display("FAIL pwm_off: got an=%b want 1111", bus.an); end
    end
  endtask

  task automatic test_tear_free();
    bit ok;
    logic [3:0] prev;
    set_inputs(16'h1111, 4'h0, 4'h0, 4'hF);
    repeat (2 * FRAME) @(negedge clk);
    sync_frame(ok);
    prev = bus.an;
    for (int i = 0; i < 2 * FRAME && ok; i++) begin
      @(negedge clk);
      if (bus.an == 4'b1101 && prev != 4'b1101) break;
      prev = bus.an;
    end
    bus.in = 16'h2222;
    n_checks++;
    if (!ok || bus.an !== 4'b1101) begin
      n_fail++; $display("FAIL tear_sync: got an=%b want 1101", bus.an);
    end
    for (int k = 0; k < 11 + 16; k++) begin
      logic [6:0] es;
      @(negedge clk);
      es = (k < 11) ? 7'h79 : 7'h24;
      n_checks++;
      if (bus.seg !== es || {bus.an, bus.seg, bus.dp} !== m_out) begin
        n_fail++; $display("FAIL tear_k%0d: got seg=%h want %h", k, bus.seg, es);
      end
    end
  endtask

  task automatic test_blank_dp();
    bit ok;
    set_inputs(16'h5555, 4'b0001, 4'b0100, 4'hF);
    repeat (2 * FRAME) @(negedge clk);
    sync_frame(ok);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (!ok || {bus.an, bus.seg, bus.dp} !== m_out) begin
        n_fail++; $display("FAIL blank_model_k%0d: got %h want %h", k, {bus.an, bus.seg, bus.dp}, m_out);
      end
      if (k == 8) begin
        n_checks++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
          n_fail++; $display("FAIL blank_digit2: got an=%b seg=%h want 1111 7f", bus.an, bus.seg);
        end
      end
      if (k == 0) begin
        n_checks++;
        if (bus.dp !== 1'b0 || bus.seg !== 7'h12) begin
          n_fail++; $display("FAIL dp_digit0: got dp=%b seg=%h want 0 12", bus.dp, bus.seg);
        end
      end
    end
  endtask

  task automatic test_lzb();
    bit ok;
    logic [6:0] es [4];
    es[0] = 7'h40; es[1] = 7'h30;
    es[2] = LZB ? 7'h7F : 7'h40; es[3] = LZB ? 7'h7F : 7'h40;
    set_inputs(16'h0030, 4'h0, 4'h0, 4'hF);
    repeat (2 * FRAME) @(negedge clk);
    sync_frame(ok);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (!ok || bus.seg !== es[k / 4] || {bus.an, bus.seg, bus.dp} !== m_out) begin
        n_fail++; $display("FAIL lzb_k%0d: got seg=%h an=%b want seg=%h", k, bus.seg, bus.an, es[k / 4]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    set_inputs(16'h1234, 4'hF, 4'h0, 4'hF);
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (bus.an == 4'b1011) begin ok = 1'b1; break; end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (!ok || {bus.an, bus.seg, bus.dp} !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++; $display("FAIL midreset_dark: got an=%b seg=%h dp=%b want 1111 7f 1", bus.an, bus.seg, bus.dp);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.seg !== 7'h40 || bus.dp !== 1'b1 || {bus.an, bus.seg, bus.dp} !== m_out) begin
        n_fail++; $display("FAIL midreset_k%0d: got an=%b seg=%h dp=%b want seg=40 dp=1", k, bus.an, bus.seg, bus.dp);
      end
    end
  endtask

  task automatic test_random();
    set_inputs(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    repeat (400) begin
      @(negedge clk); n_checks++;
      if ({bus.an, bus.seg, bus.dp} !== m_out) begin
        n_fail++; $display("FAIL random_model: got %h want %h", {bus.an, bus.seg, bus.dp}, m_out);
      end
      if ($urandom_range(7) == 0) bus.in = 16'($urandom);
      if ($urandom_range(9) == 0) bus.dp_in = 4'($urandom);
      if ($urandom_range(9) == 0) bus.blank = 4'($urandom) & 4'($urandom);
      if ($urandom_range(11) == 0) bus.brightness = 4'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_pwm();
    test_tear_free();
    test_blank_dp();
    test_lzb();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
